// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Multi-cycle load-use hazard detector. It sits beside the IF/ID and ID/EX
//   pipeline registers. It stalls the decode-stage instruction while any load
//   it reads from is still in flight. A load is in flight until its result
//   becomes forwardable, which takes LOAD_LAT cycles after it enters EX.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   if_id_src      packed decode-stage source addresses, operand i at [i*REG_AW +: REG_AW]
//   if_id_src_vld  per-operand "source is read" flags
//   id_ex_rt       destination register of the instruction in ID/EX
//   id_ex_mr       instruction in ID/EX is a load
//   flush          IF/ID and ID/EX are squashed this cycle
//   cnt_clr        synchronous clear of stall_cnt (wins over increment)
//   pc_write       PC write enable (low while stalling)
//   if_id_write    IF/ID write enable (low while stalling)
//   stall          bubble select for ID/EX
//   stall_cnt      saturating count of stalled cycles
module hazard_unit_mc #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_src,
  input  logic [NUM_SRC-1:0]        if_id_src_vld,
  input  logic [REG_AW-1:0]         id_ex_rt,
  input  logic                      id_ex_mr,
  input  logic                      flush,
  input  logic                      cnt_clr,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Tracker view: slot 0 is the load currently in ID/EX. Slots 1.. are older
  // loads that are already beyond EX.
  logic                       slot0_vld;
  logic [LOAD_LAT-1:0]        slot_vld;
  logic [LOAD_LAT*REG_AW-1:0] slot_addr;

  logic                       hit;
  logic                       hazard;
  logic                       detected;
  logic [REG_AW-1:0]          src_cur;

  logic [CNT_W-1:0]           stall_cnt_q;
  logic [CNT_W-1:0]           stall_cnt_d;

  assign slot0_vld = id_ex_mr & ~flush;

  generate
    if (LOAD_LAT > 1) begin : g_chain
      logic [LOAD_LAT-2:0]          chain_vld_q;
      logic [LOAD_LAT-2:0]          chain_vld_d;
      logic [(LOAD_LAT-1)*REG_AW-1:0] chain_addr_q;
      logic [(LOAD_LAT-1)*REG_AW-1:0] chain_addr_d;

      assign slot_vld  = {chain_vld_q, slot0_vld};
      assign slot_addr = {chain_addr_q, id_ex_rt};

      // Slot k+1 takes slot k every cycle. Stalls never hold the chain, and
      // flush does not clear it, because loads past ID always progress.
      always_comb begin
        chain_vld_d  = slot_vld[LOAD_LAT-2:0];
        chain_addr_d = slot_addr[(LOAD_LAT-1)*REG_AW-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain_vld_q  <= '0;
          chain_addr_q <= '0;
        end else begin
          chain_vld_q  <= chain_vld_d;
          chain_addr_q <= chain_addr_d;
        end
      end
    end else begin : g_single
      assign slot_vld  = slot0_vld;
      assign slot_addr = id_ex_rt;
    end
  endgenerate

  // Any valid source that matches any live slot is a hazard. Register 0 is
  // ignored when it is hard-wired to zero.
  always_comb begin
    hit     = 1'b0;
    src_cur = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_cur = if_id_src[i*REG_AW +: REG_AW];
      for (int unsigned k = 0; k < LOAD_LAT; k++) begin
        if (if_id_src_vld[i] && slot_vld[k] &&
            (src_cur == slot_addr[k*REG_AW +: REG_AW]) &&
            !(ZERO_REG && (src_cur == '0))) begin
          hit = 1'b1;
        end
      end
    end
  end

  // A flushed decode instruction is discarded, so it must not hold the PC
  // back from taking the redirect.
  assign hazard = hit & ~flush;
  // Gating with rst_n forces the reset output values while reset is held,
  // even though the detection path itself is combinational.
  assign detected = hazard & rst_n;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall       = detected;
  assign pc_write    = ~detected;
  assign if_id_write = ~detected;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed testbench for hazard_unit_mc. Three instances share one set of
// input stimulus:
//   u1 : LOAD_LAT=1, ZERO_REG=1, CNT_W=16
//   u3 : LOAD_LAT=3, ZERO_REG=1, CNT_W=4
//   u0 : LOAD_LAT=1, ZERO_REG=0, CNT_W=16
module tb_hazard_unit_mc;

  logic       clk;
  logic       rst_n;
  logic [7:0] if_id_src;
  logic [1:0] if_id_src_vld;
  logic [3:0] id_ex_rt;
  logic       id_ex_mr;
  logic       flush;
  logic       cnt_clr;

  logic        u1_pc_write, u1_if_id_write, u1_stall;
  logic [15:0] u1_stall_cnt;
  logic        u3_pc_write, u3_if_id_write, u3_stall;
  logic [3:0]  u3_stall_cnt;
  logic        u0_pc_write, u0_if_id_write, u0_stall;
  logic [15:0] u0_stall_cnt;

  int pass_cnt;
  int total_cnt;

  hazard_unit_mc #(.REG_AW(4), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .if_id_src(if_id_src), .if_id_src_vld(if_id_src_vld),
    .id_ex_rt(id_ex_rt), .id_ex_mr(id_ex_mr), .flush(flush), .cnt_clr(cnt_clr),
    .pc_write(u1_pc_write), .if_id_write(u1_if_id_write), .stall(u1_stall),
    .stall_cnt(u1_stall_cnt)
  );

  hazard_unit_mc #(.REG_AW(4), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG(1'b1), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .if_id_src(if_id_src), .if_id_src_vld(if_id_src_vld),
    .id_ex_rt(id_ex_rt), .id_ex_mr(id_ex_mr), .flush(flush), .cnt_clr(cnt_clr),
    .pc_write(u3_pc_write), .if_id_write(u3_if_id_write), .stall(u3_stall),
    .stall_cnt(u3_stall_cnt)
  );

  hazard_unit_mc #(.REG_AW(4), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .if_id_src(if_id_src), .if_id_src_vld(if_id_src_vld),
    .id_ex_rt(id_ex_rt), .id_ex_mr(id_ex_mr), .flush(flush), .cnt_clr(cnt_clr),
    .pc_write(u0_pc_write), .if_id_write(u0_if_id_write), .stall(u0_stall),
    .stall_cnt(u0_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge. Checks run 1 ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop all inputs, clear the counters and let every slot drain.
  task automatic idle_clr();
    id_ex_mr      = 1'b0;
    if_id_src_vld = 2'b00;
    if_id_src     = 8'h00;
    id_ex_rt      = 4'd0;
    flush         = 1'b0;
    cnt_clr       = 1'b1;
    tick(); tick(); tick();
    cnt_clr       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_ex_mr = 1'b1; id_ex_rt = 4'd3; if_id_src = 8'h03; if_id_src_vld = 2'b01;
    flush = 1'b0; cnt_clr = 1'b0;
    #1;
    total_cnt++;
    if (u1_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", u1_stall); else pass_cnt++;
    total_cnt++;
    if (u1_pc_write !== 1'b1) $display("FAIL reset_pc_write got %b exp 1", u1_pc_write); else pass_cnt++;
    total_cnt++;
    if (u1_if_id_write !== 1'b1) $display("FAIL reset_if_id_write got %b exp 1", u1_if_id_write); else pass_cnt++;
    total_cnt++;
    if (u3_stall_cnt !== 4'd0) $display("FAIL reset_cnt got %0d exp 0", u3_stall_cnt); else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    idle_clr();
  endtask

  task automatic test_ll1();
    idle_clr();
    id_ex_mr = 1'b1; id_ex_rt = 4'd3; if_id_src = 8'h03; if_id_src_vld = 2'b01;
    #1;
    total_cnt++;
    if (u1_stall !== 1'b1) $display("FAIL ll1_stall got %b exp 1", u1_stall); else pass_cnt++;
    total_cnt++;
    if (u1_pc_write !== 1'b0) $display("FAIL ll1_pc_write got %b exp 0", u1_pc_write); else pass_cnt++;
    total_cnt++;
    if (u1_if_id_write !== 1'b0) $display("FAIL ll1_if_id_write got %b exp 0", u1_if_id_write); else pass_cnt++;
    tick();
    id_ex_mr = 1'b0;
    #1;
    total_cnt++;
    if (u1_stall !== 1'b0) $display("FAIL ll1_release got %b exp 0", u1_stall); else pass_cnt++;
    total_cnt++;
    if (u1_stall_cnt !== 16'd1) $display("FAIL ll1_cnt got %0d exp 1", u1_stall_cnt); else pass_cnt++;
  endtask

  task automatic test_ll3();
    idle_clr();
    // Load to r5 in EX at cycle 0. The decode operand 1 reads r5.
    id_ex_mr = 1'b1; id_ex_rt = 4'd5; if_id_src = 8'h50; if_id_src_vld = 2'b10;
    #1;
    total_cnt++;
    if (u3_stall !== 1'b1) $display("FAIL ll3_cyc0 got %b exp 1", u3_stall); else pass_cnt++;
    tick();
    id_ex_mr = 1'b0;
    #1;
    total_cnt++;
    if (u3_stall !== 1'b1) $display("FAIL ll3_cyc1 got %b exp 1", u3_stall); else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (u3_stall !== 1'b1) $display("FAIL ll3_cyc2 got %b exp 1", u3_stall); else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (u3_stall !== 1'b0) $display("FAIL ll3_cyc3 got %b exp 0", u3_stall); else pass_cnt++;
    total_cnt++;
    if (u3_pc_write !== 1'b1) $display("FAIL ll3_pc_write got %b exp 1", u3_pc_write); else pass_cnt++;
    total_cnt++;
    if (u3_stall_cnt !== 4'd3) $display("FAIL ll3_cnt got %0d exp 3", u3_stall_cnt); else pass_cnt++;
  endtask

  task automatic test_masking();
    idle_clr();
    id_ex_mr = 1'b1; id_ex_rt = 4'd5; if_id_src = 8'h05; if_id_src_vld = 2'b00;
    #1;
    total_cnt++;
    if (u1_stall !== 1'b0) $display("FAIL mask_vld got %b exp 0", u1_stall); else pass_cnt++;
    if_id_src_vld = 2'b01;
    #1;
    total_cnt++;
    if (u1_stall !== 1'b1) $display("FAIL mask_vld_on got %b exp 1", u1_stall); else pass_cnt++;
    id_ex_rt = 4'd0; if_id_src = 8'h00;
    #1;
    total_cnt++;
    if (u1_stall !== 1'b0) $display("FAIL mask_zero_reg got %b exp 0", u1_stall); else pass_cnt++;
    total_cnt++;
    if (u0_stall !== 1'b1) $display("FAIL mask_no_zero_reg got %b exp 1", u0_stall); else pass_cnt++;
  endtask

  task automatic test_flush();
    idle_clr();
    id_ex_mr = 1'b1; id_ex_rt = 4'd2; if_id_src = 8'h02; if_id_src_vld = 2'b01; flush = 1'b1;
    #1;
    total_cnt++;
    if (u1_stall !== 1'b0) $display("FAIL flush_stall got %b exp 0", u1_stall); else pass_cnt++;
    total_cnt++;
    if (u1_pc_write !== 1'b1) $display("FAIL flush_pc_write got %b exp 1", u1_pc_write); else pass_cnt++;
    tick();
    id_ex_mr = 1'b0; flush = 1'b0;
    #1;
    total_cnt++;
    if (u3_stall !== 1'b0) $display("FAIL flush_slot1_clear got %b exp 0", u3_stall); else pass_cnt++;
    // The load enters unflushed. A flush on the next cycle must leave it in
    // the chain.
    id_ex_mr = 1'b1;
    tick();
    id_ex_mr = 1'b0; flush = 1'b1;
    #1;
    total_cnt++;
    if (u3_stall !== 1'b0) $display("FAIL flush_gate got %b exp 0", u3_stall); else pass_cnt++;
    tick();
    flush = 1'b0;
    #1;
    total_cnt++;
    if (u3_stall !== 1'b1) $display("FAIL flush_slot_kept got %b exp 1", u3_stall); else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (u3_stall !== 1'b0) $display("FAIL flush_drained got %b exp 0", u3_stall); else pass_cnt++;
  endtask

  task automatic test_counter();
    idle_clr();
    id_ex_mr = 1'b1; id_ex_rt = 4'd7; if_id_src = 8'h07; if_id_src_vld = 2'b01;
    for (int i = 0; i < 14; i++) tick();
    total_cnt++;
    if (u3_stall_cnt !== 4'd14) $display("FAIL cnt_14 got %0d exp 14", u3_stall_cnt); else pass_cnt++;
    for (int i = 0; i < 6; i++) tick();
    total_cnt++;
    if (u3_stall_cnt !== 4'd15) $display("FAIL cnt_saturate got %0d exp 15", u3_stall_cnt); else pass_cnt++;
    total_cnt++;
    if (u1_stall_cnt !== 16'd20) $display("FAIL cnt_wide got %0d exp 20", u1_stall_cnt); else pass_cnt++;
    total_cnt++;
    if (u3_stall !== 1'b1) $display("FAIL cnt_still_stall got %b exp 1", u3_stall); else pass_cnt++;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    total_cnt++;
    if (u3_stall_cnt !== 4'd0) $display("FAIL cnt_clr_prio got %0d exp 0", u3_stall_cnt); else pass_cnt++;
    tick();
    total_cnt++;
    if (u3_stall_cnt !== 4'd1) $display("FAIL cnt_resume got %0d exp 1", u3_stall_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    idle_clr();
    id_ex_mr = 1'b1; id_ex_rt = 4'd5; if_id_src = 8'h50; if_id_src_vld = 2'b10;
    tick();
    id_ex_mr = 1'b0;
    #1;
    total_cnt++;
    if (u3_stall !== 1'b1) $display("FAIL rst_pre_stall got %b exp 1", u3_stall); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (u3_stall !== 1'b0) $display("FAIL rst_async_stall got %b exp 0", u3_stall); else pass_cnt++;
    total_cnt++;
    if (u3_pc_write !== 1'b1) $display("FAIL rst_async_pc_write got %b exp 1", u3_pc_write); else pass_cnt++;
    total_cnt++;
    if (u3_stall_cnt !== 4'd0) $display("FAIL rst_async_cnt got %0d exp 0", u3_stall_cnt); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (u3_stall !== 1'b0) $display("FAIL rst_release_stall got %b exp 0", u3_stall); else pass_cnt++;
    tick();
    total_cnt++;
    if (u3_stall !== 1'b0) $display("FAIL rst_release_stall2 got %b exp 0", u3_stall); else pass_cnt++;
    total_cnt++;
    if (u3_stall_cnt !== 4'd0) $display("FAIL rst_release_cnt got %0d exp 0", u3_stall_cnt); else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_ll1();
    test_ll3();
    test_masking();
    test_flush();
    test_counter();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
